// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: DATA stores are queued in a byte FIFO and sent as 8N1 frames.
// STATUS and COUNT are readable combinationally so a single-cycle core can poll them.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_FF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_mem,
  input  logic [31:0] wr_mem_data,
  input  logic        we_mem,
  output logic        sel,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [3:0]       offset;
  logic             wr_data_reg;
  logic             wr_status_reg;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             ovf;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       fifo_mem [FIFO_DEPTH];

  state_t            state, state_next;
  logic [7:0]        shift, shift_next;
  logic [2:0]        bit_idx, bit_idx_next;
  logic [BAUD_W-1:0] baud, baud_next;
  logic              baud_done;
  logic              tx_next;
  logic              unused_bits;

  assign unused_bits = ^{wr_mem_data[31:8]};

  assign offset        = addr_mem[3:0];
  assign sel           = (addr_mem[31:4] == BASE_ADDR[31:4]);
  assign wr_data_reg   = we_mem && sel && (offset == 4'h0);
  assign wr_status_reg = we_mem && sel && (offset == 4'h4);
  assign full          = (count == DEPTH_CNT);
  assign empty         = (count == '0);
  // Full is judged on the pre-edge count, so a pop in the same cycle does not make room.
  assign push          = wr_data_reg && !full;
  assign pop           = (state == IDLE) && !empty;
  assign busy          = (state != IDLE);

  always_comb begin
    rd_data = '0;
    if (sel) begin
      case (offset)
        4'h4:    rd_data = {28'd0, ovf, busy, empty, full};
        4'h8:    rd_data = 32'(count);
        default: rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= wr_mem_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (wr_data_reg && full) begin
        ovf <= 1'b1;
      end else if (wr_status_reg && wr_mem_data[3]) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      baud    <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      bit_idx <= bit_idx_next;
      baud    <= baud_next;
      tx      <= tx_next;
    end
  end

  assign baud_done = (baud == BAUD_LAST);

  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    baud_next    = baud;
    case (state)
      IDLE: begin
        if (!empty) begin
          shift_next = fifo_mem[rd_ptr];
          baud_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_next    = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          baud_next = baud + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next  = '0;
          shift_next = shift >> 1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          baud_next = baud + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next  = '0;
          state_next = IDLE;
        end else begin
          baud_next = baud + BAUD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line level is derived from the upcoming state so tx leaves a flop and never glitches.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule
